// File: rtl/legv8_pkg.sv
// Shared constants, fetch FSM state type and a saturating-add helper for the
// LEGv8 instruction-fetch stage.
package legv8_pkg;

  localparam int OPCODE_W   = 11;
  localparam int INSTR_W    = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 21;
  localparam int PC_INCR    = 4;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_FULL
  } fetchStateT;

  function automatic logic [31:0] satAdd32(input logic [31:0] base, input logic [1:0] incr);
    logic [32:0] sum;
    sum = {1'b0, base} + {31'd0, incr};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/legv8_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave). Single outstanding request.
interface legv8_fetch_stage_if #(
  parameter int PC_WIDTH    = 64,
  parameter int INSTR_WIDTH = 32
);

  logic                   imem_req_valid;
  logic                   imem_req_ready;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic                   imem_resp_valid;
  logic [INSTR_WIDTH-1:0] imem_resp_data;

  modport master (
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data
  );

  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data
  );

endinterface

// File: rtl/legv8_fetch_stage_if_id_reg.sv
// IF/ID pipeline register plus a one-entry holding buffer that catches a
// response arriving while decode is stalled.
module if_id_reg #(
  parameter int PC_WIDTH    = 64,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   loadEn,
  input  logic                   bufWrEn,
  input  logic                   bufMove,
  input  logic                   consume,
  input  logic                   flush,
  input  logic [INSTR_WIDTH-1:0] newInstr,
  input  logic [PC_WIDTH-1:0]    newPc,
  output logic                   ifIdValid,
  output logic [INSTR_WIDTH-1:0] ifIdInstr,
  output logic [PC_WIDTH-1:0]    ifIdPc,
  output logic                   bufValid
);

  logic [INSTR_WIDTH-1:0] bufInstr;
  logic [PC_WIDTH-1:0]    bufPc;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifIdValid <= 1'b0;
      ifIdInstr <= '0;
      ifIdPc    <= '0;
      bufValid  <= 1'b0;
    end else if (flush) begin
      ifIdValid <= 1'b0;
      bufValid  <= 1'b0;
    end else begin
      if (loadEn) begin
        ifIdValid <= 1'b1;
        ifIdInstr <= newInstr;
        ifIdPc    <= newPc;
      end else if (bufMove) begin
        ifIdValid <= 1'b1;
        ifIdInstr <= bufInstr;
        ifIdPc    <= bufPc;
        bufValid  <= 1'b0;
      end else if (consume) begin
        ifIdValid <= 1'b0;
      end
      if (bufWrEn) begin
        bufValid <= 1'b1;
      end
    end
  end

  // NOTE: buffer payload has no reset; bufValid alone qualifies it, so the data flops stay cheap.
  always_ff @(posedge clk) begin
    if (bufWrEn) begin
      bufInstr <= newInstr;
      bufPc    <= newPc;
    end
  end

endmodule

// File: rtl/legv8_fetch_stage.sv
// LEGv8 instruction-fetch stage: PC, request FSM, IF/ID register and redirect.
// Optional FETCH_PERF_CNT_EN adds saturating fetched/dropped counters.
module legv8_fetch_stage
  import legv8_pkg::*;
#(
  parameter int                  PC_WIDTH    = 64,
  parameter int                  INSTR_WIDTH = INSTR_W,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  legv8_fetch_stage_if.master    imem,
  input  logic                   id_stall,
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirect_target,
  output logic                   if_id_valid,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [PC_WIDTH-1:0]    if_id_pc,
  output logic [OPCODE_W-1:0]    opcode
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_dropped
`endif
);

  fetchStateT          state, nextState;
  logic [PC_WIDTH-1:0] pc, nextPc;
  logic                dropFlag, nextDrop;
  logic                loadEn, bufWrEn, bufMove, respDropped;
  logic                bufValid;
  logic                ifIdFree;

  assign ifIdFree            = !if_id_valid || !id_stall;
  assign imem.imem_req_valid = rst_n && (state == S_REQ);
  assign imem.imem_addr      = pc;
  assign opcode              = if_id_instr[OPCODE_MSB:OPCODE_LSB];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      dropFlag <= 1'b0;
    end else begin
      state    <= nextState;
      pc       <= nextPc;
      dropFlag <= nextDrop;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    nextState   = state;
    nextPc      = pc;
    nextDrop    = dropFlag;
    loadEn      = 1'b0;
    bufWrEn     = 1'b0;
    bufMove     = 1'b0;
    respDropped = 1'b0;
    if (redirect) begin
      // A request already accepted must still drain; the drop flag swallows its response.
      nextPc    = redirect_target & ~PC_WIDTH'(3);
      nextState = S_REQ;
      nextDrop  = 1'b0;
      case (state)
        S_REQ: if (imem.imem_req_ready) begin
          nextState = S_WAIT;
          nextDrop  = 1'b1;
        end
        S_WAIT: if (imem.imem_resp_valid) begin
          respDropped = 1'b1;
        end else begin
          nextState = S_WAIT;
          nextDrop  = 1'b1;
        end
        default: ;
      endcase
    end else begin
      case (state)
        S_REQ: if (imem.imem_req_ready) nextState = S_WAIT;
        S_WAIT: if (imem.imem_resp_valid) begin
          if (dropFlag) begin
            respDropped = 1'b1;
            nextDrop    = 1'b0;
            nextState   = S_REQ;
          end else if (ifIdFree) begin
            loadEn    = 1'b1;
            nextPc    = pc + PC_WIDTH'(PC_INCR);
            nextState = S_REQ;
          end else begin
            bufWrEn   = 1'b1;
            nextPc    = pc + PC_WIDTH'(PC_INCR);
            nextState = S_FULL;
          end
        end
        S_FULL: if (!id_stall) begin
          bufMove   = bufValid;
          nextState = S_REQ;
        end
        default: nextState = S_REQ;
      endcase
    end
  end

  if_id_reg #(
    .PC_WIDTH   (PC_WIDTH),
    .INSTR_WIDTH(INSTR_WIDTH)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .loadEn   (loadEn),
    .bufWrEn  (bufWrEn),
    .bufMove  (bufMove),
    .consume  (if_id_valid && !id_stall),
    .flush    (redirect),
    .newInstr (imem.imem_resp_data),
    .newPc    (pc),
    .ifIdValid(if_id_valid),
    .ifIdInstr(if_id_instr),
    .ifIdPc   (if_id_pc),
    .bufValid (bufValid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [1:0] dropIncr;
  assign dropIncr = {1'b0, respDropped}
                  + {1'b0, redirect && if_id_valid}
                  + {1'b0, redirect && bufValid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      perf_fetched <= satAdd32(perf_fetched, {1'b0, loadEn || bufWrEn});
      perf_dropped <= satAdd32(perf_dropped, dropIncr);
    end
  end
`endif

endmodule

// File: tb/tb_legv8_fetch_stage.sv
// Directed self-checking bench for legv8_fetch_stage (RESET_PC = 0x100).
module tb_legv8_fetch_stage;

  localparam int PW = 64;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_stall;
  logic          redirect;
  logic [PW-1:0] redirect_target;
  logic          if_id_valid;
  logic [IW-1:0] if_id_instr;
  logic [PW-1:0] if_id_pc;
  logic [10:0]   opcode;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]   perf_fetched;
  logic [31:0]   perf_dropped;
`endif

  int passCount  = 0;
  int totalCount = 0;

  legv8_fetch_stage_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) imemBus ();

  legv8_fetch_stage #(
    .PC_WIDTH   (PW),
    .INSTR_WIDTH(IW),
    .RESET_PC   (64'h100)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (imemBus),
    .id_stall       (id_stall),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .opcode         (opcode)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_dropped   (perf_dropped)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n                   = 1'b1;
    id_stall                = 1'b0;
    redirect                = 1'b0;
    redirect_target         = '0;
    imemBus.imem_req_ready  = 1'b0;
    imemBus.imem_resp_valid = 1'b0;
    imemBus.imem_resp_data  = '0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_req_valid", 64'(imemBus.imem_req_valid), 64'd0);
    check("rst_if_id_valid", 64'(if_id_valid), 64'd0);
    check("rst_if_id_instr", 64'(if_id_instr), 64'd0);
    check("rst_if_id_pc", if_id_pc, 64'd0);
    check("rst_addr", imemBus.imem_addr, 64'h100);
    tick();
    tick();
    check("rst_req_valid_held", 64'(imemBus.imem_req_valid), 64'd0);
    #2 rst_n = 1'b1;
    #1;
    check("t1_req_valid", 64'(imemBus.imem_req_valid), 64'd1);
    check("t1_addr", imemBus.imem_addr, 64'h100);

    // Basic fetch: accept, then response one cycle later
    imemBus.imem_req_ready = 1'b1;
    tick();
    imemBus.imem_req_ready = 1'b0;
    check("t1_wait_no_req", 64'(imemBus.imem_req_valid), 64'd0);
    imemBus.imem_resp_valid = 1'b1;
    imemBus.imem_resp_data  = 32'hF840_03E1;
    tick();
    imemBus.imem_resp_valid = 1'b0;
    check("t1_if_id_valid", 64'(if_id_valid), 64'd1);
    check("t1_if_id_pc", if_id_pc, 64'h100);
    check("t1_if_id_instr", 64'(if_id_instr), 64'hF840_03E1);
    check("t1_opcode", 64'(opcode), 64'h7C2);
    check("t1_next_addr", imemBus.imem_addr, 64'h104);
    check("t1_next_req", 64'(imemBus.imem_req_valid), 64'd1);

    // Decode consumes; then two fetches under a 5-cycle stall
    tick();
    check("t2_consumed", 64'(if_id_valid), 64'd0);
    id_stall = 1'b1;
    imemBus.imem_req_ready = 1'b1;
    tick();
    imemBus.imem_req_ready  = 1'b0;
    imemBus.imem_resp_valid = 1'b1;
    imemBus.imem_resp_data  = 32'h8B02_0020;
    tick();
    imemBus.imem_resp_valid = 1'b0;
    check("t2_first_valid", 64'(if_id_valid), 64'd1);
    check("t2_first_pc", if_id_pc, 64'h104);
    imemBus.imem_req_ready = 1'b1;
    tick();
    imemBus.imem_req_ready  = 1'b0;
    imemBus.imem_resp_valid = 1'b1;
    imemBus.imem_resp_data  = 32'hCB03_0041;
    tick();
    imemBus.imem_resp_valid = 1'b0;
    check("t2_full_no_req", 64'(imemBus.imem_req_valid), 64'd0);
    check("t2_held_pc", if_id_pc, 64'h104);
    check("t2_held_instr", 64'(if_id_instr), 64'h8B02_0020);
    imemBus.imem_req_ready = 1'b1;
    tick();
    imemBus.imem_req_ready = 1'b0;
    check("t2_full_still_no_req", 64'(imemBus.imem_req_valid), 64'd0);
    check("t2_full_held_instr", 64'(if_id_instr), 64'h8B02_0020);
    id_stall = 1'b0;
    tick();
    check("t2_release_valid", 64'(if_id_valid), 64'd1);
    check("t2_release_pc", if_id_pc, 64'h108);
    check("t2_release_instr", 64'(if_id_instr), 64'hCB03_0041);
    check("t2_resume_addr", imemBus.imem_addr, 64'h10C);
    check("t2_resume_req", 64'(imemBus.imem_req_valid), 64'd1);

    // Redirect while waiting, with decode stalled on a valid entry
    id_stall = 1'b1;
    imemBus.imem_req_ready = 1'b1;
    tick();
    imemBus.imem_req_ready = 1'b0;
    check("t3_entry_held", 64'(if_id_valid), 64'd1);
    redirect        = 1'b1;
    redirect_target = 64'h203;
    tick();
    redirect = 1'b0;
    id_stall = 1'b0;
    check("t3_flushed", 64'(if_id_valid), 64'd0);
    check("t3_still_wait", 64'(imemBus.imem_req_valid), 64'd0);
    tick();
    check("t3_wait_no_req", 64'(imemBus.imem_req_valid), 64'd0);
    imemBus.imem_resp_valid = 1'b1;
    imemBus.imem_resp_data  = 32'hDEAD_BEEF;
    tick();
    imemBus.imem_resp_valid = 1'b0;
    check("t3_resp_discarded", 64'(if_id_valid), 64'd0);
    check("t3_target_addr", imemBus.imem_addr, 64'h200);
    check("t3_target_req", 64'(imemBus.imem_req_valid), 64'd1);

    // Redirect in the same cycle as the response
    imemBus.imem_req_ready = 1'b1;
    tick();
    imemBus.imem_req_ready  = 1'b0;
    imemBus.imem_resp_valid = 1'b1;
    imemBus.imem_resp_data  = 32'h1234_5678;
    redirect        = 1'b1;
    redirect_target = 64'h300;
    tick();
    imemBus.imem_resp_valid = 1'b0;
    redirect = 1'b0;
    check("t4_dropped", 64'(if_id_valid), 64'd0);
    check("t4_target_addr", imemBus.imem_addr, 64'h300);
    check("t4_target_req", 64'(imemBus.imem_req_valid), 64'd1);
    imemBus.imem_req_ready = 1'b1;
    tick();
    imemBus.imem_req_ready  = 1'b0;
    imemBus.imem_resp_valid = 1'b1;
    imemBus.imem_resp_data  = 32'hF840_83E2;
    tick();
    imemBus.imem_resp_valid = 1'b0;
    check("t4_accepted_valid", 64'(if_id_valid), 64'd1);
    check("t4_accepted_pc", if_id_pc, 64'h300);
    check("t4_accepted_instr", 64'(if_id_instr), 64'hF840_83E2);
    check("t4_next_addr", imemBus.imem_addr, 64'h304);

    // req_ready low for 4 cycles: request held stable
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_hold_req", 64'(imemBus.imem_req_valid), 64'd1);
      check("t5_hold_addr", imemBus.imem_addr, 64'h304);
    end
    imemBus.imem_req_ready = 1'b1;
    tick();
    imemBus.imem_req_ready = 1'b0;
    check("t5_accepted", 64'(imemBus.imem_req_valid), 64'd0);
    tick();
    check("t5_single_req", 64'(imemBus.imem_req_valid), 64'd0);
    imemBus.imem_resp_valid = 1'b1;
    imemBus.imem_resp_data  = 32'h9100_0421;
    tick();
    imemBus.imem_resp_valid = 1'b0;
    check("t5_pc", if_id_pc, 64'h304);
    check("t5_instr", 64'(if_id_instr), 64'h9100_0421);
    check("t5_next_addr", imemBus.imem_addr, 64'h308);

    // PC wrap at the top of the address space
    tick();
    check("t6_consumed", 64'(if_id_valid), 64'd0);
    redirect        = 1'b1;
    redirect_target = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    redirect = 1'b0;
    check("t6_masked_addr", imemBus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    imemBus.imem_req_ready = 1'b1;
    tick();
    imemBus.imem_req_ready  = 1'b0;
    imemBus.imem_resp_valid = 1'b1;
    imemBus.imem_resp_data  = 32'hD280_0020;
    tick();
    imemBus.imem_resp_valid = 1'b0;
    check("t6_wrap_pc", if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("t6_wrap_addr", imemBus.imem_addr, 64'h0);
    tick();

    // Redirect in S_REQ coinciding with acceptance
    redirect               = 1'b1;
    redirect_target        = 64'h401;
    imemBus.imem_req_ready = 1'b1;
    tick();
    redirect               = 1'b0;
    imemBus.imem_req_ready = 1'b0;
    check("t7_wait_drop", 64'(imemBus.imem_req_valid), 64'd0);
    imemBus.imem_resp_valid = 1'b1;
    imemBus.imem_resp_data  = 32'hAAAA_5555;
    tick();
    imemBus.imem_resp_valid = 1'b0;
    check("t7_dropped", 64'(if_id_valid), 64'd0);
    check("t7_target_addr", imemBus.imem_addr, 64'h400);
    check("t7_target_req", 64'(imemBus.imem_req_valid), 64'd1);

`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", 64'(perf_fetched), 64'd6);
    check("perf_dropped", 64'(perf_dropped), 64'd4);
`endif

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/legv8_fetch_stage.md
Name: legv8_fetch_stage

Overview:
- Instruction-fetch stage of the LEGv8 datapath, directly upstream of the opcode decoder/control unit.
- Owns the PC, issues single-outstanding requests to instruction memory, and captures responses into the IF/ID register.
- Drives the 11-bit opcode field (instr[31:21]) consumed by the control unit.
- Handles decode-stage stall and branch redirect/flush.

Parameters:
- PC_WIDTH, 64, width of PC and memory address.
- INSTR_WIDTH, 32, instruction word width (fixed 32 for LEGv8).
- RESET_PC, 64'h0, PC loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_addr  out  PC_WIDTH  fetch address (word-aligned).
- imem_resp_valid  in  1  instruction data valid (one pulse per accepted request, ≥1 cycle after acceptance).
- imem_resp_data  in  INSTR_WIDTH  fetched instruction.
- id_stall  in  1  decode cannot accept a new IF/ID entry.
- redirect  in  1  branch taken / flush, single-cycle pulse.
- redirect_target  in  PC_WIDTH  new PC; bits[1:0] are forced to 0.
- if_id_valid  out  1  IF/ID entry valid.
- if_id_instr  out  INSTR_WIDTH  registered instruction.
- if_id_pc  out  PC_WIDTH  PC of that instruction.
- opcode  out  11  if_id_instr[31:21] (combinational from register).

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=S_REQ, if_id_valid=0, if_id_instr=0, if_id_pc=0, drop flag=0, holding buffer empty; imem_req_valid is forced to 0 while rst_n=0.
- S_REQ: imem_req_valid=1, imem_addr=pc.
  - On req_ready, go to S_WAIT. Request is held stable until accepted.
- S_WAIT: imem_req_valid=0.
  - On resp_valid with drop=1: discard the response, clear drop, go to S_REQ.
  - On resp_valid with drop=0 and IF/ID free (if_id_valid=0 or id_stall=0): load IF/ID {instr, pc}, set valid=1, pc+=4, go to S_REQ.
  - On resp_valid with drop=0 and IF/ID blocked: store the response in the holding buffer, pc+=4, go to S_FULL.
- S_FULL: when id_stall=0, move the holding buffer into IF/ID, go to S_REQ.
- IF/ID consumption: if_id_valid=1 and id_stall=0 means decode takes the entry. If no new entry loads that cycle, if_id_valid becomes 0.
- Latency: response on cycle N appears on if_id_* at N+1. Best-case throughput is 1 instruction per 2 cycles when req_ready=1 and resp is 1 cycle after acceptance (single outstanding).
- redirect=1 overrides everything:
  - pc=target with bits[1:0]=0, if_id_valid=0, holding buffer cleared.
  - From S_REQ without req_ready, or from S_FULL: go to S_REQ.
  - From S_REQ with req_ready the same cycle: the old request is accepted; go to S_WAIT with drop=1.
  - From S_WAIT without resp_valid: stay in S_WAIT with drop=1.
  - From S_WAIT with resp_valid the same cycle: the response is dropped; go to S_REQ.
- redirect together with id_stall: the flush wins and the IF/ID entry is invalidated.
- PC wraps modulo 2^PC_WIDTH; no exception is raised.
- Reset mid-transaction: the pending response is not tracked. Memory is required to be reset by the same rst_n.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched[31:0] and perf_dropped[31:0], both reset to 0 and saturating at 32'hFFFF_FFFF.
  - perf_fetched increments per response loaded into IF/ID or the holding buffer.
  - perf_dropped increments per dropped response plus per valid IF/ID or holding entry flushed by redirect (+2 if both are flushed in the same cycle).
- Undefined: no counters and no ports; behaviour otherwise identical.

Decomposition:
- Package legv8_pkg: OPCODE_W=11, INSTR_W=32, OPCODE_MSB=31, OPCODE_LSB=21, PC_INCR=4, fetch state enum {S_REQ, S_WAIT, S_FULL}.
- Sub-module if_id_reg: the IF/ID register plus the one-entry holding buffer, with load/consume/flush controls. The PC and FSM stay in the top level.

Test Plan:
- Reset RESET_PC=0x100, req_ready=1, resp one cycle later with 0xF84003E1 → imem_addr=0x100; if_id_pc=0x100; opcode=11'h7C2; next imem_addr=0x104.
- id_stall=1 held for 5 cycles during two fetches → first instr held in IF/ID, second in the holding buffer, state S_FULL, no new request; stall release → entries delivered in order and fetching resumes at pc+8.
- redirect to 0x203 while in S_WAIT, response arrives 2 cycles later → response discarded, if_id_valid=0, next imem_addr=0x200.
- redirect in the same cycle as resp_valid → response dropped, no drop flag left set, next request at the target, the following response accepted.
- req_ready low for 4 cycles → imem_addr and imem_req_valid stable throughout; exactly one request accepted.
- PC=0xFFFF_FFFF_FFFF_FFFC fetch completes → next imem_addr=0x0; with FETCH_PERF_CNT_EN, perf_fetched matches the count of delivered instructions.
